cache_axi_arbiter: RTL and testbench
====================================

// Module: cache_axi_arbiter
// PURPOSE
//  Shares the single AXI4 master port between icache (line read) and dcache (line read / dirty-line writeback).
//  Converts each granted request into one 8-beat INCR burst and returns/consumes whole lines.
//  Sits between both caches and the SoC AXI interconnect.
//  One transaction is outstanding at a time.
// PARAMETERS
//  LINE_WORDS  8   words per cache line = burst length (arlen/awlen = LINE_WORDS-1)
//  IC_ID       0   arid used for icache reads
//  DC_ID       1   arid/awid used for dcache reads and writes
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  ic_rd_req   in   1      icache line read request, held until ic_gnt
//  ic_addr     in   32     icache line address, [4:0] ignored (forced 0)
//  ic_gnt      out  1      1-cycle pulse: icache request complete
//  ic_rd_data  out  32x8   icache line, valid from ic_gnt until the next icache read completes
//  dc_rd_req   in   1      dcache line read request, held until dc_gnt
//  dc_wr_req   in   1      dcache line writeback request, held until dc_gnt
//  dc_addr     in   32     dcache line address, [4:0] ignored
//  dc_wr_data  in   32x8   dcache writeback line, stable while dc_wr_req is high
//  dc_gnt      out  1      1-cycle pulse: dcache request complete (read: data valid; write: B received)
//  dc_rd_data  out  32x8   dcache line, valid from dc_gnt until the next dcache read completes
//  ar*         out/in      arid[3:0] araddr[31:0] arlen[7:0] arsize[2:0]=2 arburst[1:0]=INCR arvalid / arready
//  r*          in/out      rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid / rready
//  aw*         out/in      awid awaddr awlen awsize awburst awvalid / awready (same encoding as AR)
//  w*          out/in      wdata[31:0] wstrb[3:0]=4'hF wlast wvalid / wready
//  b*          in/out      bid[3:0] bresp[1:0] bvalid / bready
// BEHAVIOUR
//  Reset: state IDLE; all valid/ready/gnt outputs 0; beat counter 0; line buffers 0; owner = dcache.
//  FSM: IDLE -> AR -> R -> DONE (reads); IDLE -> AW -> W -> B -> DONE (writes); DONE -> IDLE.
//  IDLE: sample requests; if dc_wr_req and dc_rd_req both set, write wins. Latch owner, addr, op.
//  Arbitration is decided only in IDLE; the owner is fixed until its gnt. No preemption.
//  AR/AW: valid held with constant payload until ready; leave the state on handshake cycle.
//  R: rready=1; each rvalid beat writes line_buf[cnt], cnt++; exit on rlast. rid/rresp ignored.
//  W: wvalid=1, wdata=dc_wr_data[cnt]; cnt++ on wready; wlast=1 when cnt==LINE_WORDS-1.
//  B: bready=1; exit on bvalid. bresp ignored.
//  DONE: owner's gnt=1 for exactly one cycle; for reads, copy line_buf to owner's rd_data the same edge.
//  Latency, zero-wait slave: read = 11 cycles req->gnt (IDLE,AR,8xR,DONE); write = 12 (IDLE,AW,8xW,B,DONE).
//  A request dropped before gnt is still completed; its gnt is issued and may be ignored.
//  rlast before 8 beats: exit R anyway; unfilled words keep stale data. Extra beats: never accepted, rready=0.
//  cnt is 3 bits and wraps 7->0; it is cleared on entry to R/W.
//  rst mid-burst: FSM returns to IDLE immediately; the in-flight AXI burst is abandoned (SoC reset assumed common).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. The requester not served last wins when both request in IDLE; owner toggles after each DONE.
//  ARB_RR_EN undefined: fixed priority, dcache always beats icache.
// TESTING
//  icache only, addr 0x1FC0_0014, zero-wait R with data k+0x100 -> araddr=0x1FC0_0000, arlen=7, arid=0; ic_gnt at cycle 11; ic_rd_data[k]=k+0x100.
//  dcache writeback addr 0x8000_0040, data 0xA0..0xA7, wready toggling -> 8 W beats in order, wlast only on 0xA7, dc_gnt 1 cycle after bvalid.
//  ic_rd_req and dc_rd_req raised same cycle, ARB_RR_EN undefined -> dcache served first; icache AR issued only after dc_gnt.
//  Same case with ARB_RR_EN, repeated 4 times back-to-back -> grant order D,I,D,I,...
//  dc_wr_req and dc_rd_req both high -> AW issued before any AR.
//  rst asserted during beat 4 of R -> next cycle all valid/ready=0, no gnt; a new ic_rd_req is then served normally.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI4 master between icache line reads and dcache line reads/writebacks,
// one whole-line INCR burst at a time. Define ARB_RR_EN for round-robin arbitration.
module cache_axi_arbiter #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] IC_ID      = 4'd0,
  parameter logic [3:0] DC_ID      = 4'd1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_rd_req,
  input  logic [31:0]                  ic_addr,
  output logic                         ic_gnt,
  output logic [LINE_WORDS-1:0][31:0]  ic_rd_data,
  input  logic                         dc_rd_req,
  input  logic                         dc_wr_req,
  input  logic [31:0]                  dc_addr,
  input  logic [LINE_WORDS-1:0][31:0]  dc_wr_data,
  output logic                         dc_gnt,
  output logic [LINE_WORDS-1:0][31:0]  dc_rd_data,
  output logic [3:0]                   arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic [3:0]                   awid,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [31:0]                  wdata,
  output logic [3:0]                   wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [3:0]                   bid,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready
);
  localparam int          CW        = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                        state_reg, state_next;
  logic                          owner_dc_reg;
  logic                          op_wr_reg;
  logic [31:0]                   addr_reg;
  logic [CW-1:0]                 cnt_reg;
  logic [LINE_WORDS-1:0][31:0]   line_buf_reg;
  logic [LINE_WORDS-1:0][31:0]   line_next;
  logic                          dc_any;
  logic                          any_req;
  logic                          pick_dc;

  // Response id/status are not used: errors are not reported back to the caches.
  logic unused_sig;
  assign unused_sig = ^{rid, rresp, bid, bresp, op_wr_reg};

  assign dc_any  = dc_rd_req | dc_wr_req;
  assign any_req = dc_any | ic_rd_req;

`ifdef ARB_RR_EN
  logic prio_dc_reg;
  assign pick_dc = dc_any & (~ic_rd_req | prio_dc_reg);
`else
  assign pick_dc = dc_any;
`endif

  assign arid    = owner_dc_reg ? DC_ID : IC_ID;
  assign araddr  = addr_reg;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign awid    = DC_ID;
  assign awaddr  = addr_reg;
  assign awlen   = 8'(LINE_WORDS - 1);
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign wdata   = dc_wr_data[cnt_reg];
  assign wstrb   = 4'hF;
  assign wlast   = (state_reg == S_W) && (cnt_reg == CW'(LINE_WORDS - 1));

  // Line buffer with the current R beat merged in, so the final beat reaches rd_data directly.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_merge
    assign line_next[gi] = (cnt_reg == CW'(gi)) ? rdata : line_buf_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    ic_gnt     = 1'b0;
    dc_gnt     = 1'b0;
    case (state_reg)
      S_IDLE: if (any_req) state_next = (pick_dc && dc_wr_req) ? S_AW : S_AR;
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_next = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_next = S_DONE;
      end
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_next = S_W;
      end
      S_W: begin
        wvalid = 1'b1;
        if (wready && wlast) state_next = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_next = S_DONE;
      end
      S_DONE: begin
        ic_gnt     = ~owner_dc_reg;
        dc_gnt     = owner_dc_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      owner_dc_reg <= 1'b1;
      op_wr_reg    <= 1'b0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      line_buf_reg <= '0;
      ic_rd_data   <= '0;
      dc_rd_data   <= '0;
`ifdef ARB_RR_EN
      prio_dc_reg  <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (any_req) begin
          owner_dc_reg <= pick_dc;
          op_wr_reg    <= pick_dc & dc_wr_req;
          addr_reg     <= (pick_dc ? dc_addr : ic_addr) & LINE_MASK;
        end
        S_AR: if (arready) cnt_reg <= '0;
        S_AW: if (awready) cnt_reg <= '0;
        S_R: if (rvalid) begin
          line_buf_reg <= line_next;
          cnt_reg      <= cnt_reg + CW'(1);
          // rd_data is loaded as DONE is entered so it is already valid while gnt is high.
          if (rlast) begin
            if (owner_dc_reg) dc_rd_data <= line_next;
            else              ic_rd_data <= line_next;
          end
        end
        S_W: if (wready) cnt_reg <= cnt_reg + CW'(1);
`ifdef ARB_RR_EN
        S_DONE: prio_dc_reg <= ~owner_dc_reg;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Randomized scoreboard bench for cache_axi_arbiter: an AXI slave model with random
// wait states, an arbitration-order reference model and a monitor that checks each transfer.
`timescale 1ns/1ps
module tb_cache_axi_arbiter;
  localparam int LW   = 8;
  localparam int K_IC = 0;
  localparam int K_DR = 1;
  localparam int K_DW = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef logic [LW-1:0][31:0] line_t;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    line_t       line;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   zero_wait = 1'b1;
  bit   model_prio_dc = 1'b1;

  logic clk, rst;
  logic ic_rd_req, ic_gnt, dc_rd_req, dc_wr_req, dc_gnt;
  logic [31:0] ic_addr, dc_addr;
  line_t ic_rd_data, dc_rd_data, dc_wr_data;
  logic [3:0] arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, rresp, awburst, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;

  cache_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rd_data(ic_rd_data),
    .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
    .dc_gnt(dc_gnt), .dc_rd_data(dc_rd_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, expv);
    end
  endtask

  // Memory contents seen by reads; the boot line returns k+0x100.
  function automatic logic [31:0] rword(input logic [31:0] a, input int k);
    if (a == 32'h1FC0_0000) return 32'h100 + 32'(k);
    return a ^ (32'h9E37_79B9 * 32'(k + 1));
  endfunction

  // AXI slave: drives inputs on the falling edge, random stalls unless zero_wait.
  bit r_act = 0, b_pend = 0;
  int r_beat = 0, b_dly = 0;
  logic [31:0] r_addr = '0;
  initial begin
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 4'd0; rresp = 2'd0;
    awready = 0; wready = 0; bvalid = 0; bid = 4'd1; bresp = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_act = 0; b_pend = 0; arready = 0; rvalid = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0;
      end else begin
        if (r_act) begin
          rvalid = zero_wait || ($urandom_range(0, 3) != 0);
          rdata  = rword(r_addr, r_beat);
          rlast  = (r_beat == LW - 1);
          if (rvalid && rready) begin
            r_beat++;
            if (r_beat == LW) r_act = 0;
          end
        end else begin
          rvalid = 0; rlast = 0;
        end
        arready = zero_wait || ($urandom_range(0, 1) == 1);
        if (arvalid && arready) begin r_act = 1; r_addr = araddr; r_beat = 0; end
        if (b_pend) begin
          if (b_dly > 0) begin b_dly--; bvalid = 0; end
          else bvalid = 1;
          if (bvalid && bready) b_pend = 0;
        end else bvalid = 0;
        wready = zero_wait || ($urandom_range(0, 1) == 1);
        if (wvalid && wready && wlast) begin
          b_pend = 1;
          b_dly  = zero_wait ? 0 : int'($urandom_range(0, 3));
        end
        awready = zero_wait || ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Monitor: compares every handshake and grant against the front of the scoreboard.
  int wbeat = 0;
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      #1;
      if (rst) wbeat = 0;
      else begin
        if (arvalid && arready) begin
          ok = (exp_q.size() != 0) && (exp_q[0].kind != K_DW);
          chk("ar_expected", 32'(ok), 1);
          if (ok) begin
            chk("araddr", araddr, exp_q[0].addr);
            chk("arid", 32'(arid), (exp_q[0].kind == K_IC) ? 0 : 1);
            chk("ar_len_size_burst", {arlen, arsize, arburst}, {8'd7, 3'd2, 2'd1});
          end
        end
        if (awvalid && awready) begin
          ok = (exp_q.size() != 0) && (exp_q[0].kind == K_DW);
          chk("aw_expected", 32'(ok), 1);
          if (ok) begin
            chk("awaddr", awaddr, exp_q[0].addr);
            chk("aw_id_len_size_burst", {awid, awlen, awsize, awburst}, {4'd1, 8'd7, 3'd2, 2'd1});
          end
        end
        if (wvalid && wready) begin
          ok = (exp_q.size() != 0) && (exp_q[0].kind == K_DW) && (wbeat < LW);
          chk("w_expected", 32'(ok), 1);
          if (ok) begin
            chk($sformatf("wdata[%0d]", wbeat), wdata, exp_q[0].line[wbeat]);
            chk($sformatf("wlast[%0d]", wbeat), 32'(wlast), 32'(wbeat == LW - 1));
            chk("wstrb", 32'(wstrb), 32'hF);
          end
          wbeat++;
        end
        if (ic_gnt || dc_gnt) begin
          chk("gnt_onehot", 32'(ic_gnt & dc_gnt), 0);
          ok = (exp_q.size() != 0);
          chk("gnt_expected", 32'(ok), 1);
          if (ok) begin
            e = exp_q.pop_front();
            chk("gnt_owner", 32'(dc_gnt), 32'(e.kind != K_IC));
            if (e.kind == K_DW) chk("w_beat_count", wbeat, LW);
            for (int k = 0; k < LW; k++) begin
              if (e.kind == K_IC) chk($sformatf("ic_rd_data[%0d]", k), ic_rd_data[k], rword(e.addr, k));
              if (e.kind == K_DR) chk($sformatf("dc_rd_data[%0d]", k), dc_rd_data[k], rword(e.addr, k));
            end
            $display("txn kind=%0d addr=%h done", e.kind, e.addr);
          end
          wbeat = 0;
        end
      end
    end
  end

  // Raises a set of requests together, predicts the grant order and waits for all grants.
  task automatic issue(input bit ic, input bit dr, input bit dw,
                       input logic [31:0] ia, input logic [31:0] da, input line_t wl,
                       output int lat);
    bit   p_ic = ic, p_dr = dr, p_dw = dw, pick_dc;
    exp_t e;
    int   cyc;
    while (p_ic || p_dr || p_dw) begin
      if ((p_dr || p_dw) && p_ic) pick_dc = RR ? model_prio_dc : 1'b1;
      else                        pick_dc = p_dr || p_dw;
      if (pick_dc && p_dw)      begin e.kind = K_DW; e.addr = da & ~32'h1F; e.line = wl; p_dw = 0; end
      else if (pick_dc)         begin e.kind = K_DR; e.addr = da & ~32'h1F; e.line = '0; p_dr = 0; end
      else                      begin e.kind = K_IC; e.addr = ia & ~32'h1F; e.line = '0; p_ic = 0; end
      exp_q.push_back(e);
      model_prio_dc = !pick_dc;
    end
    @(negedge clk);
    ic_addr = ia; dc_addr = da; dc_wr_data = wl;
    ic_rd_req = ic; dc_rd_req = dr; dc_wr_req = dw;
    lat = 0;
    cyc = 1;
    while ((ic_rd_req || dc_rd_req || dc_wr_req) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ic_gnt) begin
        ic_rd_req = 0;
        if (lat == 0) lat = cyc;
      end
      if (dc_gnt) begin
        if (dc_wr_req) dc_wr_req = 0;
        else           dc_rd_req = 0;
        if (lat == 0) lat = cyc;
      end
    end
    chk("req_timeout_pending", {ic_rd_req, dc_rd_req, dc_wr_req}, 0);
    if (ic_rd_req || dc_rd_req || dc_wr_req) begin
      ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
      exp_q.delete();
    end
  endtask

  initial begin
    line_t wl;
    int    lat;
    int    r;
    rst = 1; ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_addr = '0; dc_addr = '0; dc_wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {arvalid, rready, awvalid, wvalid, bready, ic_gnt, dc_gnt}, 0);
    chk("rst_ic_rd_data", ic_rd_data[0], 0);
    chk("rst_dc_rd_data", dc_rd_data[7], 0);
    rst = 0;

    zero_wait = 1;
    issue(1, 0, 0, 32'h1FC0_0014, 32'h0, '0, lat);
    chk("ic_read_latency", lat, 11);

    for (int k = 0; k < LW; k++) wl[k] = 32'hA0 + 32'(k);
    issue(0, 0, 1, 32'h0, 32'h8000_0040, wl, lat);
    chk("dc_write_latency", lat, 12);

    zero_wait = 0;
    issue(0, 0, 1, 32'h0, 32'h8000_0040, wl, lat);
    repeat (4) issue(1, 1, 0, 32'h1000_0100, 32'h4000_0200, '0, lat);
    issue(0, 1, 1, 32'h0, 32'h4000_0300, wl, lat);

    // Reset during the fourth R beat of an icache read.
    zero_wait = 1;
    @(negedge clk);
    begin
      exp_t e;
      e.kind = K_IC; e.addr = 32'h2000_0000; e.line = '0;
      exp_q.push_back(e);
    end
    ic_addr = 32'h2000_0004; ic_rd_req = 1;
    repeat (5) @(negedge clk);
    rst = 1; ic_rd_req = 0; exp_q.delete(); model_prio_dc = 1;
    @(negedge clk);
    #1;
    chk("midrst_outputs", {arvalid, rready, awvalid, wvalid, bready, ic_gnt, dc_gnt}, 0);
    chk("midrst_ic_rd_data", ic_rd_data[0], 0);
    @(negedge clk);
    rst = 0;
    issue(1, 0, 0, 32'h1FC0_0000, 32'h0, '0, lat);
    chk("post_rst_ic_latency", lat, 11);

    zero_wait = 0;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(1, 7));
      for (int k = 0; k < LW; k++) wl[k] = $urandom;
      issue(r[0], r[1], r[2], $urandom, $urandom, wl, lat);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
